// File: rtl/pipeline_pkg.sv
// pipeline_pkg
// Shared constants for the pipeline blocks.
//   DEFAULT_DATA_WIDTH : payload width used by default throughout the pipeline
//   DEFAULT_FIFO_DEPTH : default number of entries in the elastic buffer
package pipeline_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_FIFO_DEPTH = 8;

endpackage : pipeline_pkg

// File: rtl/pipeline_fifo_mem.sv
// pipeline_fifo_mem
// DEPTH x DATA_WIDTH register array used as storage for pipeline_fifo.
// Ports:
//   clk      : clock, writes happen on its rising edge
//   rst      : asynchronous active-high reset, clears every entry to zero
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : write payload
//   rd_addr  : read address
//   rd_data  : asynchronous read of the addressed entry
module pipeline_fifo_mem
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_FIFO_DEPTH,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    // Storage array: cleared on reset, single synchronous write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Read is purely from registered state (array + registered address).
    assign rd_data = mem_r[rd_addr];

endmodule : pipeline_fifo_mem

// File: rtl/pipeline_fifo.sv
// pipeline_fifo
// Elastic buffer between pipeline and pipeline_insert with valid/ready on
// both sides. Order is preserved, bubbles are never stored, no bypass.
// Ports:
//   clk     : single clock
//   rst     : asynchronous active-high reset
//   u_data  : upstream payload
//   u_valid : upstream word present
//   u_ready : buffer can accept a word this cycle (registered)
//   d_data  : head-of-buffer payload
//   d_valid : head entry valid (registered)
//   d_ready : downstream takes the head this cycle
//   count   : number of stored entries, 0..DEPTH
module pipeline_fifo
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_FIFO_DEPTH,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] u_data,
    input  logic                  u_valid,
    output logic                  u_ready,
    output logic [DATA_WIDTH-1:0] d_data,
    output logic                  d_valid,
    input  logic                  d_ready,
    output logic [ADDR_WIDTH:0]   count
);

    localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   ZERO_COUNT = (ADDR_WIDTH+1)'(0);
    localparam logic [ADDR_WIDTH:0]   ONE_COUNT  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ONE_PTR    = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] wr_ptr_r;
    logic [ADDR_WIDTH-1:0] rd_ptr_r;
    logic [ADDR_WIDTH-1:0] wr_ptr_next_s;
    logic [ADDR_WIDTH-1:0] rd_ptr_next_s;
    logic [ADDR_WIDTH:0]   count_r;
    logic [ADDR_WIDTH:0]   count_next_s;
    logic                  u_ready_r;
    logic                  d_valid_r;
    logic                  push_s;
    logic                  pop_s;

    // Handshakes use the registered flags only, so d_data has no path from inputs.
    always_comb begin
        push_s = u_valid && u_ready_r;
        pop_s  = d_valid_r && d_ready;
    end

    // Next pointers and occupancy; pointers wrap naturally at power-of-two DEPTH.
    always_comb begin
        wr_ptr_next_s = wr_ptr_r;
        rd_ptr_next_s = rd_ptr_r;
        count_next_s  = count_r;
        if (push_s) begin
            wr_ptr_next_s = wr_ptr_r + ONE_PTR;
        end else begin
            wr_ptr_next_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_next_s = rd_ptr_r + ONE_PTR;
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + ONE_COUNT;
            2'b01:   count_next_s = count_r - ONE_COUNT;
            default: count_next_s = count_r;
        endcase
    end

    // State registers; flags are derived from the next occupancy so they are
    // exact in the cycle after the change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            count_r   <= ZERO_COUNT;
            u_ready_r <= 1'b0;
            d_valid_r <= 1'b0;
        end else begin
            wr_ptr_r  <= wr_ptr_next_s;
            rd_ptr_r  <= rd_ptr_next_s;
            count_r   <= count_next_s;
            u_ready_r <= (count_next_s != FULL_COUNT);
            d_valid_r <= (count_next_s != ZERO_COUNT);
        end
    end

    pipeline_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push_s),
        .wr_addr (wr_ptr_r),
        .wr_data (u_data),
        .rd_addr (rd_ptr_r),
        .rd_data (d_data)
    );

    assign u_ready = u_ready_r;
    assign d_valid = d_valid_r;
    assign count   = count_r;

endmodule : pipeline_fifo

// File: tb/tb_pipeline_fifo.sv
// tb_pipeline_fifo
// Directed self-checking bench for pipeline_fifo (DATA_WIDTH=32, DEPTH=8).
module tb_pipeline_fifo;

    logic        clk;
    logic        rst;
    logic [31:0] u_data;
    logic        u_valid;
    logic        u_ready;
    logic [31:0] d_data;
    logic        d_valid;
    logic        d_ready;
    logic [3:0]  count;

    int check_cnt;
    int pass_cnt;

    pipeline_fifo #(
        .DATA_WIDTH (32),
        .DEPTH      (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .u_data  (u_data),
        .u_valid (u_valid),
        .u_ready (u_ready),
        .d_data  (d_data),
        .d_valid (d_valid),
        .d_ready (d_ready),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, got, got, exp, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int unsigned wr_n;
    int unsigned rd_n;
    int unsigned gap;
    int unsigned stall;
    int unsigned cyc;
    logic        will_push;
    logic        will_pop;
    logic        hold_before;
    logic [31:0] held_data;

    initial begin
        check_cnt = 0;
        pass_cnt  = 0;
        rst     = 1'b1;
        u_data  = 32'd0;
        u_valid = 1'b0;
        d_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_value("rst_u_ready", {31'd0, u_ready}, 32'd0);
        check_value("rst_d_valid", {31'd0, d_valid}, 32'd0);
        check_value("rst_count",   {28'd0, count},   32'd0);
        check_value("rst_d_data",  d_data,           32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check_value("post_rst_u_ready", {31'd0, u_ready}, 32'd1);
        check_value("post_rst_d_valid", {31'd0, d_valid}, 32'd0);

        // Fill with d_ready low
        for (int i = 0; i < 8; i++) begin
            check_value("fill_u_ready_before", {31'd0, u_ready}, 32'd1);
            u_valid = 1'b1;
            u_data  = 32'(i);
            step();
        end
        check_value("fill_count",   {28'd0, count},   32'd8);
        check_value("fill_u_ready", {31'd0, u_ready}, 32'd0);
        check_value("fill_d_valid", {31'd0, d_valid}, 32'd1);
        u_data = 32'hDEAD_BEEF;
        for (int i = 0; i < 20; i++) begin
            step();
            check_value("full_hold_d_data", d_data, 32'd0);
            check_value("full_hold_count",  {28'd0, count}, 32'd8);
        end

        // Full + single pop: no push that cycle, push lands the next cycle
        u_valid = 1'b1;
        u_data  = 32'd8;
        d_ready = 1'b1;
        step();
        check_value("fullpop_count",   {28'd0, count},   32'd7);
        check_value("fullpop_u_ready", {31'd0, u_ready}, 32'd1);
        check_value("fullpop_d_data",  d_data,           32'd1);
        d_ready = 1'b0;
        step();
        check_value("refill_count",   {28'd0, count},   32'd8);
        check_value("refill_u_ready", {31'd0, u_ready}, 32'd0);
        u_valid = 1'b0;

        // Drain: expect 1..8 in order
        d_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            check_value("drain_d_data", d_data, 32'(k));
            step();
        end
        check_value("drain_count",   {28'd0, count},   32'd0);
        check_value("drain_d_valid", {31'd0, d_valid}, 32'd0);

        // Empty with d_ready high: no underflow
        u_valid = 1'b0;
        d_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check_value("empty_d_valid", {31'd0, d_valid}, 32'd0);
            check_value("empty_count",   {28'd0, count},   32'd0);
        end

        // Steady stream 100..199 with one cycle latency, count stays 1
        u_valid = 1'b1;
        d_ready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            u_data = 32'(100 + k);
            step();
            check_value("stream_d_data", d_data, 32'(100 + k));
            check_value("stream_count",  {28'd0, count}, 32'd1);
        end
        u_valid = 1'b0;
        step();
        check_value("stream_end_count", {28'd0, count}, 32'd0);
        d_ready = 1'b0;

        // Random bubbles and stalls, 100 words through several pointer wraps
        wr_n  = 0;
        rd_n  = 0;
        gap   = 0;
        stall = 0;
        cyc   = 0;
        while ((rd_n < 100) && (cyc < 5000)) begin
            u_valid = (wr_n < 100) && (gap == 0);
            u_data  = wr_n;
            d_ready = (stall == 0);
            will_push   = u_valid && u_ready;
            will_pop    = d_valid && d_ready;
            hold_before = d_valid && !d_ready;
            held_data   = d_data;
            if (will_pop) begin
                check_value("rand_order", d_data, rd_n);
            end
            step();
            cyc++;
            if (hold_before) begin
                check_value("rand_hold_d_data",  d_data, held_data);
                check_value("rand_hold_d_valid", {31'd0, d_valid}, 32'd1);
            end
            if (will_push) begin
                wr_n++;
                gap = $urandom_range(0, 3);
            end else if (!u_valid && (gap > 0)) begin
                gap--;
            end
            if (will_pop) begin
                rd_n++;
                stall = $urandom_range(0, 3);
            end else if (stall > 0) begin
                stall--;
            end
        end
        u_valid = 1'b0;
        d_ready = 1'b0;
        check_value("rand_words_out", rd_n, 32'd100);
        check_value("rand_end_count", {28'd0, count}, 32'd0);

        // Reset mid-operation at count 5
        u_valid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            u_data = 32'(i);
            step();
        end
        u_valid = 1'b0;
        check_value("pre_rst_count", {28'd0, count}, 32'd5);
        #2;
        rst = 1'b1;
        #1;
        check_value("midrst_d_valid", {31'd0, d_valid}, 32'd0);
        check_value("midrst_u_ready", {31'd0, u_ready}, 32'd0);
        check_value("midrst_count",   {28'd0, count},   32'd0);
        check_value("midrst_d_data",  d_data,           32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step();
        check_value("midrst_release_u_ready", {31'd0, u_ready}, 32'd1);
        u_valid = 1'b1;
        u_data  = 32'd42;
        step();
        u_valid = 1'b0;
        check_value("midrst_first_d_data",  d_data,           32'd42);
        check_value("midrst_first_d_valid", {31'd0, d_valid}, 32'd1);
        check_value("midrst_first_count",   {28'd0, count},   32'd1);
        d_ready = 1'b1;
        step();
        check_value("midrst_final_count", {28'd0, count}, 32'd0);
        d_ready = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule : tb_pipeline_fifo
